// File: rtl/spi_master_ctrl_pkg.sv
// rtl/spi_master_ctrl_pkg.sv - shared constants for the SPI master sequencer
//
// Purpose: FSM state encodings and SPI mode constants shared by the
//          spi_master_ctrl slice.
// Contents:
//   ST_IDLE/ST_SETUP/ST_SHIFT/ST_HOLD  2-bit sequencer state encodings
//   SPI_CPOL/SPI_CPHA                   clock polarity/phase (mode 0 only today)
package spi_master_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Mode 0: sck idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period tick generator for the SPI master
//
// Purpose: counts clk cycles 0..CLK_DIV-1 and pulses tick on the last count,
//          marking the end of one sck half-period.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   clr   in   hold counter at zero (no tick while asserted)
//   tick  out  one-cycle pulse every CLK_DIV cycles while clr is low
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  // Wrapping on tick means every state entered on a tick starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - mode 0 SPI master sequencer for a single slave
//
// Purpose: accepts a WIDTH-bit word via start/busy/done, drives sck/cs_n,
//          shifts tx MSB-first on mosi and collects miso into rx_data.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (aborts any transfer)
//   start    in   transfer request, only honoured in IDLE
//   tx_data  in   word to send, latched on the accept cycle
//   busy     out  transfer in progress
//   done     out  one-cycle pulse, rx_data valid
//   rx_data  out  last received word, held until the next done
//   sck      out  SPI clock, idles low
//   cs_n     out  chip select, active low
//   mosi     out  serial data out, MSB first
//   miso     in   serial data in, MSB first
module spi_master_ctrl #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sck,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  import spi_master_ctrl_pkg::*;

  localparam int BW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             miso_q;
  logic             tick;
  logic             div_clr;

  // Divider is parked at zero in IDLE so SETUP always starts a full half-period.
  assign div_clr = (state == ST_IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sck     <= SPI_CPOL;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      miso_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SETUP;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            mosi    <= tx_data[WIDTH-1];
            shreg   <= tx_data;
            bit_cnt <= '0;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!sck) begin
              // Rising edge: capture miso; it enters the shift register on the
              // following fall so the untransmitted LSBs are not overwritten.
              sck     <= 1'b1;
              miso_q  <= miso;
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              sck   <= 1'b0;
              shreg <= {shreg[WIDTH-2:0], miso_q};
              if (bit_cnt == BW'(WIDTH)) begin
                state <= ST_HOLD;
              end else begin
                mosi <= shreg[WIDTH-2];
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state   <= ST_IDLE;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= shreg;
            mosi    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: WIDTH=8, CLK_DIV=2
  logic       start_a = 1'b0;
  logic [7:0] tx_a = 8'h00;
  logic       busy_a, done_a, sck_a, cs_n_a, mosi_a, miso_a;
  logic [7:0] rx_a;

  // DUT B: WIDTH=8, CLK_DIV=1, always loopback
  logic       start_b = 1'b0;
  logic [7:0] tx_b = 8'h00;
  logic       busy_b, done_b, sck_b, cs_n_b, mosi_b;
  logic [7:0] rx_b;

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .tx_data(tx_a), .busy(busy_a),
    .done(done_a), .rx_data(rx_a), .sck(sck_a), .cs_n(cs_n_a), .mosi(mosi_a),
    .miso(miso_a)
  );

  spi_master_ctrl #(.WIDTH(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .busy(busy_b),
    .done(done_b), .rx_data(rx_b), .sck(sck_b), .cs_n(cs_n_b), .mosi(mosi_b),
    .miso(mosi_b)
  );

  // Slave model for DUT A: loopback or a mode 0 slave shifting out sw MSB first.
  logic       lb_a = 1'b1;
  logic [7:0] sw = 8'h00;
  logic [3:0] sidx = 4'd0;
  always @(negedge sck_a or posedge cs_n_a) begin
    if (cs_n_a) sidx <= 4'd0;
    else        sidx <= sidx + 4'd1;
  end
  assign miso_a = lb_a ? mosi_a : ((sidx < 4'd8) ? sw[3'd7 - sidx[2:0]] : 1'b0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       lb;
    logic [7:0] slave;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[5];

  task automatic run_a(input vec_t v, input string tag);
    int         cyc;
    int         rises;
    logic [7:0] bits;
    logic       prev;
    lb_a = v.lb;
    sw   = v.slave;
    @(negedge clk);
    tx_a = v.tx;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk({tag, " busy_after_accept"}, 32'(busy_a), 32'd1);
    chk({tag, " cs_n_after_accept"}, 32'(cs_n_a), 32'd0);
    cyc = 0;
    rises = 0;
    bits = 8'h00;
    prev = sck_a;
    while (!done_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!prev && sck_a) begin
        rises++;
        bits = {bits[6:0], mosi_a};
      end
      prev = sck_a;
    end
    chk({tag, " cs_to_done"}, 32'(cyc), 32'd36);
    chk({tag, " sck_rises"}, 32'(rises), 32'd8);
    chk({tag, " mosi_bits"}, 32'(bits), 32'(v.exp_mosi));
    chk({tag, " rx_data"}, 32'(rx_a), 32'(v.exp_rx));
    chk({tag, " cs_n_at_done"}, 32'(cs_n_a), 32'd1);
    chk({tag, " mosi_at_done"}, 32'(mosi_a), 32'd0);
    chk({tag, " busy_at_done"}, 32'(busy_a), 32'd0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 32'(done_a), 32'd0);
  endtask

  initial begin
    int         cyc;
    int         dones;
    int         ndone;
    int         nr;
    int         hrun;
    int         maxhigh;
    int         hi;
    logic       started;
    logic       prevb;
    logic [7:0] got_rx;
    int         dcyc[2];
    logic [7:0] drx[2];
    int         rise_cyc[16];

    vecs[0] = '{tx: 8'hA5, lb: 1'b1, slave: 8'h00, exp_rx: 8'hA5, exp_mosi: 8'hA5};
    vecs[1] = '{tx: 8'h00, lb: 1'b0, slave: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'h00};
    vecs[2] = '{tx: 8'hFF, lb: 1'b0, slave: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF};
    vecs[3] = '{tx: 8'h5A, lb: 1'b0, slave: 8'hC3, exp_rx: 8'hC3, exp_mosi: 8'h5A};
    vecs[4] = '{tx: 8'h81, lb: 1'b1, slave: 8'h00, exp_rx: 8'h81, exp_mosi: 8'h81};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy_a), 32'd0);
    chk("rst done", 32'(done_a), 32'd0);
    chk("rst cs_n", 32'(cs_n_a), 32'd1);
    chk("rst sck", 32'(sck_a), 32'd0);
    chk("rst mosi", 32'(mosi_a), 32'd0);
    chk("rst rx", 32'(rx_a), 32'd0);
    chk("rst cs_n_b", 32'(cs_n_b), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_a(vecs[i], $sformatf("vec%0d", i));
    end

    // start re-pulsed and tx_data changed while busy
    lb_a = 1'b1;
    @(negedge clk);
    tx_a = 8'h3C;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    tx_a = 8'hFF;
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    start_a = 1'b0;
    dones = 0;
    got_rx = 8'h00;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_a) begin
        dones++;
        got_rx = rx_a;
      end
    end
    chk("busy_ignore done_count", 32'(dones), 32'd1);
    chk("busy_ignore rx", 32'(got_rx), 32'h3C);

    // Reset after the third sck rise
    @(negedge clk);
    tx_a = 8'hC6;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    nr = 0;
    cyc = 0;
    prevb = sck_a;
    while (nr < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!prevb && sck_a) nr++;
      prevb = sck_a;
    end
    chk("abort reached_rise3", 32'(nr), 32'd3);
    rst = 1'b1;
    #1;
    chk("abort cs_n", 32'(cs_n_a), 32'd1);
    chk("abort sck", 32'(sck_a), 32'd0);
    chk("abort busy", 32'(busy_a), 32'd0);
    chk("abort rx", 32'(rx_a), 32'd0);
    dones = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    chk("abort no_done", 32'(dones), 32'd0);
    run_a('{tx: 8'hC6, lb: 1'b1, slave: 8'h00, exp_rx: 8'hC6, exp_mosi: 8'hC6}, "after_abort");

    // DUT B: start held high, two words back-to-back at CLK_DIV=1
    @(negedge clk);
    tx_b = 8'h01;
    start_b = 1'b1;
    cyc = 0;
    ndone = 0;
    nr = 0;
    hrun = 0;
    maxhigh = 0;
    hi = 0;
    started = 1'b0;
    prevb = 1'b0;
    dcyc[0] = 0; dcyc[1] = 0;
    drx[0] = 8'h00; drx[1] = 8'h00;
    for (int k = 0; k < 16; k++) rise_cyc[k] = 0;
    while (ndone < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy_b && !cs_n_b && tx_b == 8'h01) tx_b = 8'h80;
      if (!prevb && sck_b) begin
        if (nr < 16) rise_cyc[nr] = cyc;
        nr++;
      end
      prevb = sck_b;
      if (sck_b) begin
        hrun++;
        if (hrun > maxhigh) maxhigh = hrun;
      end else begin
        hrun = 0;
      end
      if (!cs_n_b) started = 1'b1;
      if (started && cs_n_b && !(done_b && ndone == 1)) hi++;
      if (done_b) begin
        dcyc[ndone] = cyc;
        drx[ndone] = rx_b;
        ndone++;
        if (ndone == 2) start_b = 1'b0;
      end
    end
    chk("b2b done_count", 32'(ndone), 32'd2);
    chk("b2b done_gap", 32'(dcyc[1] - dcyc[0]), 32'd19);
    chk("b2b rx0", 32'(drx[0]), 32'h01);
    chk("b2b rx1", 32'(drx[1]), 32'h80);
    chk("b2b cs_n_high_cycles", 32'(hi), 32'd1);
    chk("div1 rises", 32'(nr), 32'd16);
    chk("div1 max_high_run", 32'(maxhigh), 32'd1);
    chk("div1 word0_rise_span", 32'(rise_cyc[7] - rise_cyc[0]), 32'd14);
    chk("div1 word1_rise_span", 32'(rise_cyc[15] - rise_cyc[8]), 32'd14);
    repeat (3) @(negedge clk);
    chk("b2b idle_after", 32'(busy_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
